fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of every data word; legal values are 4 or more.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the requester count; legal values are 2 to 4.
REQ-003 Parameter MAX_LEN, default 64, SHALL set the maximum body words per packet; legal values are 1 to 255.
REQ-004 clk_in  input  1  SHALL be the single clock, the write-side clock of the downstream FIFO; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset, sampled on clk_in.
REQ-006 req  input  NUM_REQ  SHALL be per-requester "word available", one bit per requester.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  SHALL carry the requester words, with requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  input  NUM_REQ  SHALL mark the current word of requester i as the final word of its packet.
REQ-009 req_ack  output  NUM_REQ  SHALL be a one-hot pulse meaning the word of requester i is consumed this cycle.
REQ-010 fifo_data  output  DATA_WIDTH  SHALL be the word driven to the FIFO data_in.
REQ-011 fifo_enable  output  1  SHALL be the write strobe driven to the FIFO enable_in.
REQ-012 fifo_full  input  1  SHALL be the FIFO full_in flag.
REQ-013 grant_valid  output  1  SHALL be high while a packet is granted (states HEADER and BODY).
REQ-014 grant_id  output  2  SHALL give the index of the granted requester and SHALL be 0 when grant_valid is low.
REQ-015 pkt_count  output  16  SHALL count completed packets and SHALL wrap at 0xFFFF -> 0.
REQ-016 err_len  output  1  SHALL be a sticky length-overrun flag.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, HEADER and BODY.
REQ-018 In IDLE with any req bit high, the block SHALL grant round-robin, starting the search at (last_grant+1) mod NUM_REQ, and SHALL move to HEADER on the next edge.
REQ-019 After reset, last_grant SHALL equal NUM_REQ-1, so requester 0 has highest priority.
REQ-020 In HEADER, when fifo_full is low, the block SHALL assert fifo_enable for one cycle with fifo_data = {all-ones in bits [DATA_WIDTH-1:2], grant_id}, then move to BODY; when fifo_full is high it SHALL hold HEADER with no write.
REQ-021 In BODY, fifo_enable, req_ack[g] and fifo_data = req_data[g] SHALL all assert combinationally, in the same cycle, exactly when req[g] is high and fifo_full is low (g = grant_id).
REQ-022 When req[g] is low in BODY, the block SHALL insert a bubble: no write, no ack, state held.
REQ-023 A write of a word with req_last[g] high SHALL return the FSM to IDLE, set last_grant to g and increment pkt_count on the same edge.
REQ-024 A 9-bit body counter SHALL clear on entry to BODY and increment on each body write.
REQ-025 If the MAX_LEN-th body write has req_last[g] low, the block SHALL set err_len, return to IDLE, set last_grant to g and leave pkt_count unchanged.
REQ-026 Requests in other lanes, including req[g] on non-granted cycles, SHALL NOT be acked and SHALL NOT affect the active grant.
REQ-027 No FIFO write SHALL occur in any cycle where fifo_full is high.
REQ-028 No FIFO write SHALL occur in IDLE.
REQ-029 At most one req_ack bit SHALL be high in any cycle.
REQ-030 Grant latency from IDLE with req high to the header write SHALL be 1 cycle when the FIFO is not full.
REQ-031 There SHALL be no IDLE gap for a new grant beyond the single IDLE cycle after a packet end.

Reset
REQ-032 On reset the block SHALL force state=IDLE, last_grant=NUM_REQ-1, body counter=0, pkt_count=0 and err_len=0.
REQ-033 On reset all outputs SHALL be 0: req_ack, fifo_enable, fifo_data, grant_valid and grant_id.
REQ-034 A reset during HEADER or BODY SHALL abandon the packet immediately, with no further write on the reset cycle.
REQ-035 err_len SHALL be cleared only by reset.

Verification
REQ-036 Single packet: after reset, req[1] high with 3 words (last on the 3rd) and full low -> header 0xFD, then 3 data writes on consecutive cycles, pkt_count=1, then grant_valid low.
REQ-037 Round-robin: req[0] and req[2] both held high with 1-word packets -> grant order 0,2,0,2 and headers 0xFC,0xFE alternating.
REQ-038 Backpressure: fifo_full high for 4 cycles mid-body -> no fifo_enable and no req_ack during those cycles; the word is held and written on the first cycle full is low; nothing is lost or duplicated.
REQ-039 Overrun: MAX_LEN=4 with a requester sending 6 words and no last -> 1 header + 4 body writes, err_len=1, pkt_count unchanged, then the FSM re-arbitrates.
REQ-040 Bubble plus reset: req[g] drops for 2 cycles mid-body -> no writes; then reset asserted mid-body -> all outputs 0 the next cycle, and requester 0 is granted first afterward.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter that lets NUM_REQ packet sources share one FIFO write port.
// A granted packet is sent as one header word followed by the requester's body words.
// The arbiter holds the grant until the word marked last is written, or until
// MAX_LEN body words have been written without a last marker.
// fifo_enable, req_ack and fifo_data follow the inputs combinationally in the same
// cycle, so a word is consumed on the same edge that writes it into the FIFO.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_LEN    = 64
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_enable,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [1:0]                    grant_id,
    output logic [15:0]                   pkt_count,
    output logic                          err_len
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BODY   = 2'd2
    } state_t;

    // After reset the search starts one past the top requester, i.e. at requester 0.
    localparam logic [1:0] LAST_GRANT_RST = 2'(NUM_REQ - 1);
    // Body count value seen while the MAX_LEN-th body word is being written.
    localparam logic [8:0] BODY_LAST_CNT  = 9'(MAX_LEN - 1);

    state_t        state_q,      state_d;
    logic [1:0]    grant_q,      grant_d;
    logic [1:0]    last_grant_q, last_grant_d;
    logic [8:0]    body_cnt_q,   body_cnt_d;
    logic [15:0]   pkt_count_q,  pkt_count_d;
    logic          err_len_q,    err_len_d;

    logic                  req_g_s;
    logic                  last_g_s;
    logic [DATA_WIDTH-1:0] data_g_s;
    logic [DATA_WIDTH-1:0] header_s;

    // First requester with a word available, searching from one past the last grant.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                           input logic [1:0]         last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((int'(last) + k) % NUM_REQ);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Lane of the currently granted requester, plus the header word that names it.
    always_comb begin
        req_g_s  = req[grant_q];
        last_g_s = req_last[grant_q];
        data_g_s = req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
        header_s = {{(DATA_WIDTH-2){1'b1}}, grant_q};
    end

    // Next-state logic and same-cycle FIFO write / acknowledge outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        body_cnt_d   = body_cnt_q;
        pkt_count_d  = pkt_count_q;
        err_len_d    = err_len_q;
        req_ack      = {NUM_REQ{1'b0}};
        fifo_enable  = 1'b0;
        fifo_data    = {DATA_WIDTH{1'b0}};
        grant_valid  = 1'b0;
        grant_id     = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(req, last_grant_q);
                    state_d = ST_HEADER;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_HEADER: begin
                grant_valid = 1'b1;
                grant_id    = grant_q;
                if (!fifo_full) begin
                    fifo_enable = 1'b1;
                    fifo_data   = header_s;
                    body_cnt_d  = 9'd0;
                    state_d     = ST_BODY;
                end else begin
                    state_d = ST_HEADER;
                end
            end

            ST_BODY: begin
                grant_valid = 1'b1;
                grant_id    = grant_q;
                if (req_g_s && !fifo_full) begin
                    fifo_enable      = 1'b1;
                    fifo_data        = data_g_s;
                    req_ack[grant_q] = 1'b1;
                    body_cnt_d       = body_cnt_q + 9'd1;
                    if (last_g_s) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                        pkt_count_d  = pkt_count_q + 16'd1;
                    end else if (body_cnt_q == BODY_LAST_CNT) begin
                        // Packet ran past MAX_LEN: drop the grant, count nothing.
                        err_len_d    = 1'b1;
                        state_d      = ST_IDLE;
                        last_grant_d = grant_q;
                    end else begin
                        state_d = ST_BODY;
                    end
                end else begin
                    // Bubble or backpressure: hold the word and the grant.
                    state_d = ST_BODY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset abandons any packet at once: no write or ack on the reset cycle.
        if (reset) begin
            req_ack     = {NUM_REQ{1'b0}};
            fifo_enable = 1'b0;
            fifo_data   = {DATA_WIDTH{1'b0}};
            grant_valid = 1'b0;
            grant_id    = 2'd0;
        end else begin
            grant_valid = grant_valid;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= LAST_GRANT_RST;
            body_cnt_q   <= 9'd0;
            pkt_count_q  <= 16'd0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            body_cnt_q   <= body_cnt_d;
            pkt_count_q  <= pkt_count_d;
            err_len_q    <= err_len_d;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_len   = err_len_q;

endmodule
